// File: rtl/tone_divider_pkg.sv
// Shared constants and state encoding for the tone divider and its upstream
// note decoder / sequencer.
`timescale 1ns/1ps
package tone_divider_pkg;

    localparam int TONE_W = 11;
    localparam logic [TONE_W-1:0] TONE_REST = 11'h7FF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        REST = 2'd2
    } state_e;

endpackage

// File: rtl/tone_divider_if.sv
// Note-control / speaker bundle between the note sequencer and the tone divider.
`timescale 1ns/1ps
interface tone_divider_if
    import tone_divider_pkg::*;
#(
    parameter int W = TONE_W
) ();

    logic         en;
    logic [W-1:0] tone;
    logic         spks;
    logic         carry;
    logic         active;
    logic [W-1:0] tone_q;

    modport master (
        output en, tone,
        input  spks, carry, active, tone_q
    );

    modport slave (
        input  en, tone,
        output spks, carry, active, tone_q
    );

endinterface

// File: rtl/tone_divider.sv
// Programmable square-wave tone generator: an up-counter preset to the note
// value runs to all-ones, and each terminal count ends one half-period.
//
// state | meaning
// IDLE  | disabled, speaker silent, counter cleared
// RUN   | counting toward terminal count, speaker toggles at each carry
// REST  | enabled but silent, waiting for a non-rest note
`timescale 1ns/1ps
module tone_divider
    import tone_divider_pkg::*;
#(
    parameter int           W         = TONE_W,
    parameter logic [W-1:0] REST_CODE = TONE_REST
) (
    input  logic          clk,
    input  logic          rst_n,
    tone_divider_if.slave bus
);

    state_e       state, state_nxt;
    logic [W-1:0] cnt, cnt_nxt;
    logic [W-1:0] tone_q, tone_q_nxt;
    logic         spks, spks_nxt;
    logic         active;
    logic         carry;

    // Decoded purely from registers so the strobe never sees input glitches.
    assign carry = (state == RUN) && (cnt == REST_CODE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            tone_q <= REST_CODE;
            spks   <= 1'b0;
            active <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            tone_q <= tone_q_nxt;
            spks   <= spks_nxt;
            active <= (state_nxt == RUN);
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        tone_q_nxt = tone_q;
        spks_nxt   = spks;
        if (!bus.en) begin
            state_nxt  = IDLE;
            cnt_nxt    = '0;
            tone_q_nxt = REST_CODE;
            spks_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt    = bus.tone;
                    tone_q_nxt = bus.tone;
                    state_nxt  = (bus.tone != REST_CODE) ? RUN : REST;
                end
                RUN: begin
                    // The note input is only looked at on the carry edge.
                    if (carry) begin
                        if (bus.tone != REST_CODE) begin
                            spks_nxt   = ~spks;
                            cnt_nxt    = bus.tone;
                            tone_q_nxt = bus.tone;
                        end else begin
                            spks_nxt   = 1'b0;
                            tone_q_nxt = REST_CODE;
                            state_nxt  = REST;
                        end
                    end else if (cnt != REST_CODE) begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                REST: begin
                    spks_nxt = 1'b0;
                    if (bus.tone != REST_CODE) begin
                        cnt_nxt    = bus.tone;
                        tone_q_nxt = bus.tone;
                        state_nxt  = RUN;
                    end
                end
                default: begin
                    state_nxt  = IDLE;
                    cnt_nxt    = '0;
                    tone_q_nxt = REST_CODE;
                    spks_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign bus.spks   = spks;
    assign bus.carry  = carry;
    assign bus.active = active;
    assign bus.tone_q = tone_q;

endmodule

// File: tb/tb_tone_divider.sv
// Randomized and directed checks of tone_divider against a half-period
// countdown reference model.
`timescale 1ns/1ps
module tb_tone_divider;
    import tone_divider_pkg::*;

    localparam int           W       = TONE_W;
    localparam logic [W-1:0] RC      = 11'h7FF;
    localparam int           HP_FULL = 2048;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    tone_divider_if #(.W(W)) bus ();

    tone_divider #(.W(W), .REST_CODE(RC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: 0 = disabled, 1 = playing, 2 = resting.
    // m_left counts cycles remaining in the current half-period.
    int           m_mode;
    logic         m_spks;
    logic [W-1:0] m_tq;
    int           m_left;

    task automatic model_reset();
        m_mode = 0;
        m_spks = 1'b0;
        m_tq   = RC;
        m_left = 0;
    endtask

    task automatic model_edge(input logic e, input logic [W-1:0] t);
        if (!e) begin
            model_reset();
        end else if (m_mode == 1) begin
            if (m_left == 1) begin
                if (t != RC) begin
                    m_spks = ~m_spks;
                    m_tq   = t;
                    m_left = HP_FULL - int'(t);
                end else begin
                    m_spks = 1'b0;
                    m_tq   = RC;
                    m_mode = 2;
                end
            end else begin
                m_left--;
            end
        end else if (m_mode == 0 || t != RC) begin
            m_tq = t;
            if (t != RC) begin
                m_mode = 1;
                m_left = HP_FULL - int'(t);
            end else begin
                m_mode = 2;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".spks"},   32'(bus.spks),   32'(m_spks));
        chk({tag, ".carry"},  32'(bus.carry),  32'(m_mode == 1 && m_left == 1));
        chk({tag, ".active"}, 32'(bus.active), 32'(m_mode == 1));
        chk({tag, ".tone_q"}, 32'(bus.tone_q), 32'(m_tq));
    endtask

    task automatic cycle(input logic e, input logic [W-1:0] t);
        bus.en   = e;
        bus.tone = t;
        @(posedge clk);
        model_edge(e, t);
        @(negedge clk);
        check_all("cyc");
    endtask

    function automatic logic [W-1:0] pick_tone();
        logic [W-1:0] t;
        case ($urandom_range(0, 5))
            0:       t = RC;
            1:       t = 11'h7FE;
            2:       t = 11'h7FD;
            default: t = 11'h7A0 + W'($urandom_range(0, 94));
        endcase
        return t;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           first;
        int           second;
        int           third;
        int           n_carry;
        logic         e;
        logic [W-1:0] t;

        bus.en   = 1'b0;
        bus.tone = RC;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // Nothing happens while disabled after reset release.
        for (int i = 0; i < 3; i++) cycle(1'b0, 11'h7FD);

        // Minimum-style period: carry every third cycle.
        n_carry = 0;
        for (int i = 1; i <= 18; i++) begin
            cycle(1'b1, 11'h7FD);
            if (bus.carry) n_carry++;
        end
        chk("min_carry_cnt", n_carry, 6);

        // Note change part-way through a half-period.
        cycle(1'b0, RC);
        first = 0; second = 0; third = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle(1'b1, (i <= 4) ? 11'h7F0 : 11'h7F8);
            if (i == 16) chk("nc_tq_hold", 32'(bus.tone_q), 32'h7F0);
            if (i == 17) chk("nc_tq_new", 32'(bus.tone_q), 32'h7F8);
            if (bus.carry) begin
                if (first == 0) first = i;
                else if (second == 0) second = i;
                else if (third == 0) third = i;
            end
        end
        chk("nc_first_carry", first, 16);
        chk("nc_second_carry", second, 24);
        chk("nc_third_carry", third, 32);

        // Rest note taken at the carry edge, then resume with 7FE.
        cycle(1'b1, RC);
        chk("rest_active", 32'(bus.active), 32'd0);
        chk("rest_spks", 32'(bus.spks), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, RC);
        cycle(1'b1, 11'h7FE);
        chk("rest_load_tq", 32'(bus.tone_q), 32'h7FE);
        chk("rest_load_spks", 32'(bus.spks), 32'd0);
        cycle(1'b1, 11'h7FE);
        chk("rest_carry", 32'(bus.carry), 32'd1);
        cycle(1'b1, 11'h7FE);
        chk("rest_rise", 32'(bus.spks), 32'd1);

        // Enable drop mid-period and restart.
        cycle(1'b0, RC);
        for (int i = 0; i < 100; i++) cycle(1'b1, 11'h305);
        cycle(1'b0, 11'h305);
        chk("endrop_spks", 32'(bus.spks), 32'd0);
        chk("endrop_active", 32'(bus.active), 32'd0);
        chk("endrop_tq", 32'(bus.tone_q), 32'h7FF);
        first = 0;
        for (int i = 1; i <= 1400 && first == 0; i++) begin
            cycle(1'b1, 11'h305);
            if (bus.carry) first = i;
        end
        chk("endrop_first_carry", first, 1275);

        // Asynchronous reset between edges while the speaker is high.
        cycle(1'b0, RC);
        for (int i = 1; i <= 20; i++) cycle(1'b1, 11'h7F0);
        chk("pre_rst_spks", 32'(bus.spks), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_spks", 32'(bus.spks), 32'd0);
        chk("arst_active", 32'(bus.active), 32'd0);
        chk("arst_tq", 32'(bus.tone_q), 32'h7FF);
        chk("arst_carry", 32'(bus.carry), 32'd0);
        model_reset();
        #1 rst_n = 1'b1;

        // Longest half-period.
        first = 0; second = 0;
        for (int i = 1; i <= 4200; i++) begin
            cycle(1'b1, 11'h000);
            if (bus.carry) begin
                if (first == 0) first = i;
                else if (second == 0) second = i;
            end
        end
        chk("long_first_carry", first, 2048);
        chk("long_spacing", second - first, 2048);

        // Randomized note stream with occasional enable drops.
        cycle(1'b0, RC);
        t = pick_tone();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) t = pick_tone();
            e = ($urandom_range(0, 59) != 0);
            cycle(e, t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
